// File: rtl/key_sw_input.sv
// Switch/pushbutton front end: synchronizes SW/KEY, debounces both keys, and
// captures SW on each KEY[0] press into a single-entry valid/ready holding register.
module key_sw_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [9:0] SW,
   input  logic [1:0] KEY,
   output logic [1:0] key_level,
   output logic [1:0] key_press,
   output logic [7:0] data_out,
   output logic [1:0] sel_out,
   output logic       valid,
   input  logic       ready,
   output logic       overrun
);

   localparam int unsigned NUM_KEYS = 2;
   localparam int unsigned CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {S_IDLE, S_FULL} state_t;

   logic [9:0]                   r_sw_meta, r_sw_sync;
   logic [NUM_KEYS-1:0]          r_key_meta, r_key_sync;
   logic [NUM_KEYS-1:0]          w_pressed;
   logic [NUM_KEYS-1:0][CW-1:0]  r_cnt;
   logic [NUM_KEYS-1:0]          r_level, r_press;

   state_t     r_state, w_state_nxt;
   logic [7:0] r_data,  w_data_nxt;
   logic [1:0] r_sel,   w_sel_nxt;
   logic       r_ovr,   w_ovr_nxt;

   // Keys reset to the released level so a key held through reset is seen as a new press.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_sw_meta  <= '0;
         r_sw_sync  <= '0;
         r_key_meta <= '1;
         r_key_sync <= '1;
      end else begin
         r_sw_meta  <= SW;
         r_sw_sync  <= r_sw_meta;
         r_key_meta <= KEY;
         r_key_sync <= r_key_meta;
      end
   end

   assign w_pressed = ~r_key_sync;

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_cnt   <= '0;
         r_level <= '0;
         r_press <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            r_press[i] <= 1'b0;
            if (w_pressed[i] == r_level[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               // Count would reach DEBOUNCE_CYCLES: accept the new level.
               r_cnt[i]   <= '0;
               r_level[i] <= ~r_level[i];
               r_press[i] <= ~r_level[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_data  <= '0;
         r_sel   <= '0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_sel   <= w_sel_nxt;
         r_ovr   <= w_ovr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_sel_nxt   = r_sel;
      w_ovr_nxt   = r_ovr;
      case (r_state)
         S_IDLE: begin
            if (r_press[0]) begin
               w_data_nxt  = r_sw_sync[7:0];
               w_sel_nxt   = r_sw_sync[9:8];
               w_state_nxt = S_FULL;
            end
         end
         S_FULL: begin
            if (ready) begin
               if (r_press[0]) begin
                  w_data_nxt = r_sw_sync[7:0];
                  w_sel_nxt  = r_sw_sync[9:8];
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else if (r_press[0]) begin
               // Holding register occupied: drop the new capture and flag it.
               w_ovr_nxt = 1'b1;
            end
         end
      endcase
   end

   assign key_level = r_level;
   assign key_press = r_press;
   assign data_out  = r_data;
   assign sel_out   = r_sel;
   assign valid     = (r_state == S_FULL);
   assign overrun   = r_ovr;

endmodule

// File: tb/tb_key_sw_input.sv
// Bench for key_sw_input with DEBOUNCE_CYCLES=4; captures checked against a queue of expected SW values.
module tb_key_sw_input;

   logic       CLOCK_50 = 1'b0;
   logic       resetn   = 1'b1;
   logic [9:0] SW       = '0;
   logic [1:0] KEY      = 2'b11;
   logic       ready    = 1'b0;
   logic [1:0] key_level, key_press;
   logic [7:0] data_out;
   logic [1:0] sel_out;
   logic       valid, overrun;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [9:0] exp_q[$];
   logic [9:0] exp;

   key_sw_input #(.DEBOUNCE_CYCLES(4)) dut (
      .CLOCK_50(CLOCK_50), .resetn(resetn), .SW(SW), .KEY(KEY),
      .key_level(key_level), .key_press(key_press), .data_out(data_out),
      .sel_out(sel_out), .valid(valid), .ready(ready), .overrun(overrun)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   task automatic wait_press(input int maxc, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (key_press[0] !== 1'b1 && n < maxc);
   endtask

   task automatic release_keys();
      KEY   = 2'b11;
      ready = 1'b0;
      tick(12);
   endtask

   task automatic test_reset();
      SW = 10'h3FF; KEY = 2'b00; ready = 1'b1;
      #2 resetn = 1'b0;
      #1;
      n_checks++;
      if ({key_level, key_press, data_out, sel_out, valid, overrun} !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_async: got %h exp 0", {key_level, key_press, data_out, sel_out, valid, overrun});
      end
      tick(3);
      n_checks++;
      if ({key_level, key_press, data_out, sel_out, valid, overrun} !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_held: got %h exp 0", {key_level, key_press, data_out, sel_out, valid, overrun});
      end
      KEY = 2'b11; ready = 1'b0; SW = '0;
      resetn = 1'b1;
      tick(3);
      n_checks++;
      if ({key_level, valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_after: got %b exp 000", {key_level, valid});
      end
   endtask

   task automatic test_clean_press();
      int pulses;
      SW = 10'h2A5; ready = 1'b0; KEY = 2'b10;
      exp_q.push_back(10'h2A5);
      for (int c = 1; c <= 6; c++) begin
         tick();
         n_checks++;
         if (key_press !== ((c == 6) ? 2'b01 : 2'b00)) begin
            n_fail++;
            $display("FAIL clean_latency c=%0d: got %b exp %b", c, key_press, (c == 6) ? 2'b01 : 2'b00);
         end
      end
      tick();
      n_checks++;
      if ({valid, key_press} !== 3'b100) begin
         n_fail++;
         $display("FAIL clean_valid: got %b exp 100", {valid, key_press});
      end
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL clean_sb: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({sel_out, data_out} !== exp) begin
            n_fail++; $display("FAIL clean_data: got %h exp %h", {sel_out, data_out}, exp);
         end
      end
      ready = 1'b1; tick(); ready = 1'b0;
      n_checks++;
      if (valid !== 1'b0) begin
         n_fail++; $display("FAIL clean_drain: valid got %b exp 0", valid);
      end
      KEY = 2'b11; pulses = 0;
      repeat (12) begin
         tick();
         if (key_press !== 2'b00) pulses++;
      end
      n_checks++;
      if (pulses !== 0 || key_level !== 2'b00) begin
         n_fail++; $display("FAIL release_no_pulse: pulses %0d level %b exp 0 00", pulses, key_level);
      end
   endtask

   task automatic test_bounce();
      int pulses, first;
      SW = 10'h1C3; pulses = 0;
      for (int c = 0; c < 20; c++) begin
         KEY[0] = ((c / 2) % 2) ? 1'b1 : 1'b0;
         tick();
         if (key_press[0]) pulses++;
      end
      n_checks++;
      if (pulses !== 0) begin
         n_fail++; $display("FAIL bounce_quiet: pulses %0d exp 0", pulses);
      end
      KEY[0] = 1'b0; exp_q.push_back(10'h1C3);
      pulses = 0; first = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (key_press[0]) begin
            pulses++;
            if (first == 0) first = c;
         end
      end
      n_checks++;
      if (pulses !== 1 || first !== 6) begin
         n_fail++; $display("FAIL bounce_pulse: pulses %0d at %0d exp 1 at 6", pulses, first);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL bounce_sb: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({valid, sel_out, data_out} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL bounce_data: got %h exp %h", {valid, sel_out, data_out}, {1'b1, exp});
         end
      end
      ready = 1'b1; tick(); ready = 1'b0;
      release_keys();
   endtask

   task automatic test_handshake();
      int n;
      SW = 10'h3C5; KEY = 2'b10; exp_q.push_back(10'h3C5);
      wait_press(20, n);
      n_checks++;
      if (n !== 6) begin
         n_fail++; $display("FAIL hs_latency: got %0d exp 6", n);
      end
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL hs_sb: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({valid, sel_out, data_out} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL hs_data: got %h exp %h", {valid, sel_out, data_out}, {1'b1, exp});
         end
      end
      SW = 10'h000;
      for (int c = 1; c <= 5; c++) begin
         tick();
         n_checks++;
         if ({valid, sel_out, data_out} !== 11'h7C5) begin
            n_fail++; $display("FAIL hs_hold c=%0d: got %h exp 7c5", c, {valid, sel_out, data_out});
         end
      end
      ready = 1'b1; tick(); ready = 1'b0;
      n_checks++;
      if (valid !== 1'b0) begin
         n_fail++; $display("FAIL hs_drop: valid got %b exp 0", valid);
      end
      release_keys();
   endtask

   task automatic test_key1();
      int p1, vseen;
      ready = 1'b1; KEY = 2'b01; p1 = 0; vseen = 0;
      repeat (12) begin
         tick();
         if (key_press[1]) p1++;
         if (valid || key_press[0]) vseen++;
      end
      n_checks++;
      if (p1 !== 1 || vseen !== 0 || key_level !== 2'b10) begin
         n_fail++; $display("FAIL key1_isolated: p1 %0d vseen %0d level %b exp 1 0 10", p1, vseen, key_level);
      end
      release_keys();
   endtask

   task automatic test_simultaneous();
      int n;
      SW = 10'h155; KEY = 2'b10; exp_q.push_back(10'h155);
      wait_press(20, n);
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL sim_sb1: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({valid, sel_out, data_out} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL sim_first: got %h exp %h", {valid, sel_out, data_out}, {1'b1, exp});
         end
      end
      KEY = 2'b11; tick(12);
      SW = 10'h2AA; KEY = 2'b10; exp_q.push_back(10'h2AA);
      wait_press(20, n);
      n_checks++;
      if (n !== 6 || valid !== 1'b1) begin
         n_fail++; $display("FAIL sim_setup: latency %0d valid %b exp 6 1", n, valid);
      end
      ready = 1'b1; tick(); ready = 1'b0;
      n_checks++;
      if ({valid, overrun} !== 2'b10) begin
         n_fail++; $display("FAIL sim_state: valid/overrun got %b exp 10", {valid, overrun});
      end
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL sim_sb2: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({sel_out, data_out} !== exp) begin
            n_fail++; $display("FAIL sim_second: got %h exp %h", {sel_out, data_out}, exp);
         end
      end
      ready = 1'b1; tick(); ready = 1'b0;
      n_checks++;
      if (valid !== 1'b0) begin
         n_fail++; $display("FAIL sim_drain: valid got %b exp 0", valid);
      end
      release_keys();
   endtask

   task automatic test_overrun();
      int n;
      SW = 10'h011; KEY = 2'b10; exp_q.push_back(10'h011);
      wait_press(20, n);
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL ovr_sb: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({valid, overrun, sel_out, data_out} !== {2'b10, exp}) begin
            n_fail++; $display("FAIL ovr_first: got %h exp %h", {valid, overrun, sel_out, data_out}, {2'b10, exp});
         end
      end
      KEY = 2'b11; tick(12);
      SW = 10'h022; KEY = 2'b10;
      wait_press(20, n);
      tick();
      n_checks++;
      if ({valid, overrun, data_out} !== 10'h311) begin
         n_fail++; $display("FAIL ovr_set: got %h exp 311", {valid, overrun, data_out});
      end
      tick(3);
      ready = 1'b1; tick(); ready = 1'b0;
      tick(2);
      n_checks++;
      if ({valid, overrun} !== 2'b01) begin
         n_fail++; $display("FAIL ovr_sticky: valid/overrun got %b exp 01", {valid, overrun});
      end
      release_keys();
   endtask

   task automatic test_reset_midop();
      int n, p0, p1, first;
      SW = 10'h0F0; KEY = 2'b10; exp_q.push_back(10'h0F0);
      wait_press(20, n);
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL rst_sb: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({valid, sel_out, data_out} !== {1'b1, exp}) begin
            n_fail++; $display("FAIL rst_capture: got %h exp %h", {valid, sel_out, data_out}, {1'b1, exp});
         end
      end
      KEY = 2'b00; tick(3);
      #1 resetn = 1'b0;
      #1;
      exp_q.delete();
      n_checks++;
      if ({key_level, key_press, data_out, sel_out, valid, overrun} !== 15'h0) begin
         n_fail++; $display("FAIL rst_async: got %h exp 0", {key_level, key_press, data_out, sel_out, valid, overrun});
      end
      tick(2);
      SW = 10'h0E7; resetn = 1'b1; exp_q.push_back(10'h0E7);
      p0 = 0; p1 = 0; first = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (key_press[1]) p1++;
         if (key_press[0]) begin
            p0++;
            if (first == 0) first = c;
         end
      end
      n_checks++;
      if (p0 !== 1 || p1 !== 1 || first !== 6) begin
         n_fail++; $display("FAIL rst_repress: p0 %0d p1 %0d at %0d exp 1 1 6", p0, p1, first);
      end
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++; $display("FAIL rst_sb2: queue empty");
      end else begin
         exp = exp_q.pop_front();
         if ({valid, overrun, sel_out, data_out} !== {2'b10, exp}) begin
            n_fail++; $display("FAIL rst_fresh: got %h exp %h", {valid, overrun, sel_out, data_out}, {2'b10, exp});
         end
      end
      ready = 1'b1; tick(); ready = 1'b0;
      release_keys();
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_handshake();
      test_key1();
      test_simultaneous();
      test_overrun();
      test_reset_midop();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: %0d entries exp 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
